// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
//   INSTR_BYTES      : bytes per instruction word (PC stride)
//   XLEN             : instruction/address width carried in fetch entries
//   DEFAULT_RESET_PC : default PC after reset
//   fetch_state_t    : RUN (fetching) / HALT (stopped after a misaligned redirect)
//   fetch_entry_t    : one buffered fetch, instruction word plus its PC
package riscv_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned XLEN        = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries.
//   clk, rst : clock and synchronous active-high reset
//   push     : enqueue din (accepted when not full, or when full and popping)
//   pop      : dequeue the head entry (ignored when empty)
//   flush    : discard all entries; wins over push and pop
//   din      : entry to enqueue
//   head     : entry at the FIFO head (zero after reset)
//   count    : number of valid entries
//   full     : count == DEPTH
//   empty    : count == 0
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // DEPTH is a power of two, so pointers wrap at DEPTH by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch initiator.
// Holds the PC, issues sequential word-aligned reads to the instruction
// memory, buffers each returned word with its PC and hands it to decode.
//   clk, rst          : clock and synchronous active-high reset
//   imem_addr         : byte address to instruction memory (the PC register)
//   imem_instruction  : combinational read data for imem_addr
//   redirect_valid/pc : load a new PC; flushes all buffered entries
//   out_valid/ready   : decode handshake; a transfer happens on a rising edge
//                       where out_valid and out_ready are both high and
//                       redirect_valid is low. out_instruction/out_pc hold
//                       steady while out_valid is high and out_ready is low.
//   out_instruction   : instruction at the buffer head
//   out_pc            : PC of the buffer head
//   misaligned_error  : sticky; set by a redirect target with bits [1:0] != 0
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = 8,
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter logic [31:0] RESET_PC          = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [INSTRUCTION_WIDTH-1:0] imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
  input  logic                         redirect_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [INSTRUCTION_WIDTH-1:0] out_pc,
  output logic                         misaligned_error
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

  // Parameter sanity, caught at elaboration.
  if (INSTRUCTION_WIDTH != XLEN) begin : g_bad_width
    $error("INSTRUCTION_WIDTH must equal riscv_pkg::XLEN");
  end
  if (ADDR_WIDTH < 3 || ADDR_WIDTH > INSTRUCTION_WIDTH) begin : g_bad_addr_width
    $error("ADDR_WIDTH out of range");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be 4-byte aligned");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  fetch_state_t                 state_q, state_d;
  logic [INSTRUCTION_WIDTH-1:0] pc_q, pc_d;
  logic                         err_q, err_d;

  fetch_entry_t     wr_entry;
  fetch_entry_t     head;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic             unused_full;
  logic             push, pop;

  assign unused_full = full;

  assign imem_addr        = pc_q;
  assign out_valid        = ~empty;
  assign out_instruction  = head.instruction;
  assign out_pc           = head.pc;
  assign misaligned_error = err_q;

  assign pop  = out_valid & out_ready;
  // A redirect blocks the push so the flush cannot race a new entry in.
  assign push = (state_q == RUN) & ~redirect_valid &
                ((count < CNT_W'(FIFO_DEPTH)) | pop);

  assign wr_entry.instruction = imem_instruction;
  assign wr_entry.pc          = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        err_d   = 1'b1;
        state_d = HALT;
      end else begin
        pc_d    = redirect_pc;
        state_d = RUN;
      end
    end else if (push) begin
      pc_d = pc_q + INSTRUCTION_WIDTH'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (wr_entry),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        misaligned_error;

  int checks = 0;
  int errors = 0;

  // expected {instruction, pc} of each delivered entry, in order
  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch #(
    .ADDR_WIDTH        (8),
    .INSTRUCTION_WIDTH (32),
    .RESET_PC          (32'h0000_0000),
    .FIFO_DEPTH        (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .misaligned_error (misaligned_error)
  );

  // instruction memory: 64 words, word i = 0x1000_0000 + i, indexed by addr[7:2]
  assign imem_instruction = 32'h1000_0000 + {26'd0, imem_addr[7:2]};

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [5:0] idx;
    idx = pc[7:2];
    return 32'h1000_0000 + {26'd0, idx};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({mem_word(pc), pc});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s undelivered=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && out_valid && out_ready && !redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_entry actual_pc=%h required=none", out_pc);
      end else begin
        e = exp_q.pop_front();
        if (out_pc !== e[31:0] || out_instruction !== e[63:32]) begin
          errors++;
          $display("FAIL entry actual=%h/%h required=%h/%h",
                   out_pc, out_instruction, e[31:0], e[63:32]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_instr", out_instruction, 32'h0);
    check("reset_out_pc", out_pc, 32'h0);
    check("reset_imem_addr", imem_addr, 32'h0);
    check("reset_err", {31'd0, misaligned_error}, 32'd0);

    // streaming: one entry per cycle, first valid one cycle after release
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
    tick();
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_pc", out_pc, 32'h0);
    repeat (8) tick();
    check_drained("stream");

    // stall from reset: two pushes, then hold
    rst       = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("stall_imem_addr", imem_addr, 32'h8);
    check("stall_out_pc", out_pc, 32'h0);
    check("stall_out_instr", out_instruction, 32'h1000_0000);
    check("stall_valid", {31'd0, out_valid}, 32'd1);

    out_ready = 1'b1;
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    repeat (3) tick();
    check_drained("stall_release");

    // redirect with full FIFO and out_ready=1: head 0xC dropped, one bubble
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("redirect_bubble", {31'd0, out_valid}, 32'd0);
    check("redirect_addr", imem_addr, 32'h40);
    expect_pc(32'h40);
    expect_pc(32'h44);
    tick();
    check("redirect_pc_head", out_pc, 32'h40);
    tick();
    tick();
    check_drained("redirect");

    // misaligned redirect: halt, pc holds at 0x4C
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    check("misaligned_err", {31'd0, misaligned_error}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_valid", {31'd0, out_valid}, 32'd0);
      check("halt_addr", imem_addr, 32'h4C);
    end

    // aligned redirect leaves HALT; error stays sticky
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    expect_pc(32'h80);
    expect_pc(32'h84);
    repeat (3) tick();
    check("resume_err_sticky", {31'd0, misaligned_error}, 32'd1);
    check_drained("resume");

    // wrap past the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    expect_pc(32'hFFFF_FFF8);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000);
    repeat (4) tick();
    check_drained("wrap");

    // reset during a stall, together with a redirect and out_ready
    out_ready = 1'b0;
    tick();
    tick();
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h44;
    out_ready      = 1'b1;
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_addr", imem_addr, 32'h0);
    check("rst2_err", {31'd0, misaligned_error}, 32'd0);
    check("rst2_out_pc", out_pc, 32'h0);
    tick();
    check("rst2_first_valid", {31'd0, out_valid}, 32'd1);
    check("rst2_first_instr", out_instruction, 32'h1000_0000);
    tick();
    check_drained("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
